// File: rtl/mem_access_unit.sv
// Load/store unit on the initiator side of the data-memory port.
// Sub-doubleword stores do a read-modify-write because the memory always writes 8 bytes.
`ifndef D_WORD_WIDTH
`define D_WORD_WIDTH 64
`endif

module mem_access_unit #(
    parameter int DATA_DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [`D_WORD_WIDTH-1:0] req_addr,
    input  logic [`D_WORD_WIDTH-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic [`D_WORD_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_error,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [`D_WORD_WIDTH-1:0] mem_addr,
    output logic [`D_WORD_WIDTH-1:0] mem_data_wr,
    input  logic [`D_WORD_WIDTH-1:0] mem_data_rd,
    input  logic                     dmem_error
);

    localparam int W = `D_WORD_WIDTH;
    localparam logic [W-1:0] LAST_ADDR = W'(DATA_DEPTH - 8);

    typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_t;

    state_t         state;
    logic [W-1:0]   addr_q;
    logic [W-1:0]   wdata_q;
    logic [W-1:0]   merge_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic           oob;

    function automatic logic [W-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return {{(W-8){1'b0}},  8'hFF};
            2'b01:   return {{(W-16){1'b0}}, 16'hFFFF};
            2'b10:   return {{(W-32){1'b0}}, 32'hFFFF_FFFF};
            default: return '1;
        endcase
    endfunction

    function automatic logic [W-1:0] extend_load(input logic [W-1:0] rd,
                                                 input logic [1:0] size,
                                                 input logic uns);
        case (size)
            2'b00:   return {{(W-8){rd[7]   & ~uns}}, rd[7:0]};
            2'b01:   return {{(W-16){rd[15] & ~uns}}, rd[15:0]};
            2'b10:   return {{(W-32){rd[31] & ~uns}}, rd[31:0]};
            default: return rd;
        endcase
    endfunction

    assign oob = req_addr > LAST_ADDR;

    // Strobes come straight from the state register so an async reset kills them at once.
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign mem_read    = (state == LOAD) || (state == ST_RD);
    assign mem_write   = (state == ST_WR);
    assign mem_addr    = (state != IDLE) ? addr_q : '0;
    assign mem_data_wr = (state == ST_WR) ? merge_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (oob) begin
                            rsp_rdata <= '0;
                            rsp_error <= 1'b1;
                            state     <= RESP;
                        end else if (!req_write) begin
                            state <= LOAD;
                        end else if (req_size == 2'b11) begin
                            merge_q <= req_wdata;
                            state   <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= extend_load(mem_data_rd, size_q, uns_q);
                    rsp_error <= dmem_error;
                    state     <= RESP;
                end
                ST_RD: begin
                    merge_q <= (mem_data_rd & ~size_mask(size_q)) | (wdata_q & size_mask(size_q));
                    if (dmem_error) begin
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    rsp_rdata <= '0;
                    rsp_error <= dmem_error;
                    state     <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array data memory model.
// Expected values are hand-computed constants.
`ifndef D_WORD_WIDTH
`define D_WORD_WIDTH 64
`endif

module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_data_wr;
    logic [63:0] mem_data_rd;
    logic        dmem_error;

    logic [7:0]  mem [0:1031];
    logic        errOnRead;
    int          rdCnt;
    int          wrCnt;
    int          bothCnt;
    logic [63:0] lastWrData;
    int          total;
    int          bad;

    mem_access_unit #(.DATA_DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
        .dmem_error(dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_data_rd = '0;
        for (int i = 0; i < 8; i++) mem_data_rd[i*8 +: 8] = mem[int'(mem_addr[9:0]) + i];
    end

    assign dmem_error = errOnRead & mem_read;

    // Memory commits the 8-byte write on the rising edge, like the real array.
    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < 8; i++) mem[int'(mem_addr[9:0]) + i] = mem_data_wr[i*8 +: 8];
    end

    always @(negedge clk) begin
        if (mem_read) rdCnt++;
        if (mem_write) begin
            wrCnt++;
            lastWrData = mem_data_wr;
        end
        if (mem_read && mem_write) bothCnt++;
    end

    function automatic logic [63:0] getMem64(input int a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mem[a + i];
        return v;
    endfunction

    task automatic setMem64(input int a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem[a + i] = v[i*8 +: 8];
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    // Issue one request, wait for the response and measure accept-to-response latency.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 output logic [63:0] rdata, output logic err, output int lat);
        bit got;
        int n;
        @(negedge clk);
        rdCnt = 0;
        wrCnt = 0;
        checkOutput("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        got = 0; n = 0; lat = -1; rdata = '0; err = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                got = 1; lat = n; rdata = rsp_rdata; err = rsp_error;
            end
        end
        if (!got) checkOutput("rsp_timeout", 64'd0, 64'd1);
        else begin
            @(negedge clk);
            checkOutput("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic checkLoad(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [63:0] addr, input logic [63:0] expData);
        logic [63:0] rd;
        logic        er;
        int          lat;
        applyStimulus(1'b0, sz, uns, addr, 64'd0, rd, er, lat);
        checkOutput({tag, "_data"}, rd, expData);
        checkOutput({tag, "_err"}, 64'(er), 64'd0);
        checkOutput({tag, "_lat"}, 64'(lat), 64'd2);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        total = 0; bad = 0; rdCnt = 0; wrCnt = 0; bothCnt = 0; lastWrData = '0;
        errOnRead = 1'b0;
        for (int i = 0; i < 1032; i++) mem[i] = 8'h00;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        rst_n = 1'b0;

        #12;
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_error", 64'(rsp_error), 64'd0);
        checkOutput("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        checkOutput("rst_addr", mem_addr, 64'd0);
        checkOutput("rst_wdata", mem_data_wr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sign and zero extension of a byte load.
        mem[16] = 8'h80;
        checkLoad("lb", 2'b00, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_rd_cycles", 64'(rdCnt), 64'd1);
        checkLoad("lbu", 2'b00, 1'b1, 64'h10, 64'h80);

        // Sub-doubleword store merges into the existing doubleword.
        setMem64(32, 64'h1122_3344_5566_7788);
        applyStimulus(1'b1, 2'b01, 1'b0, 64'h20, 64'hFFFF_FFFF_0000_BEEF, rd, er, lat);
        checkOutput("sh_lat", 64'(lat), 64'd3);
        checkOutput("sh_err", 64'(er), 64'd0);
        checkOutput("sh_rdata", rd, 64'd0);
        checkOutput("sh_rd_cycles", 64'(rdCnt), 64'd1);
        checkOutput("sh_wr_cycles", 64'(wrCnt), 64'd1);
        checkOutput("sh_merge", lastWrData, 64'h1122_3344_5566_BEEF);
        checkLoad("ld_20", 2'b11, 1'b0, 64'h20, 64'h1122_3344_5566_BEEF);
        checkLoad("lh_20", 2'b01, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_BEEF);
        checkLoad("lhu_20", 2'b01, 1'b1, 64'h20, 64'h0000_0000_0000_BEEF);
        checkLoad("lh_21", 2'b01, 1'b0, 64'h21, 64'h0000_0000_0000_66BE);
        checkLoad("lb_21", 2'b00, 1'b0, 64'h21, 64'hFFFF_FFFF_FFFF_FFBE);
        checkLoad("lw_21", 2'b10, 1'b0, 64'h21, 64'h0000_0000_4455_66BE);
        setMem64(48, 64'h0000_0000_8000_0001);
        checkLoad("lw_30", 2'b10, 1'b0, 64'h30, 64'hFFFF_FFFF_8000_0001);
        checkLoad("lwu_30", 2'b10, 1'b1, 64'h30, 64'h0000_0000_8000_0001);

        // Last legal doubleword, then one byte past it.
        applyStimulus(1'b1, 2'b11, 1'b0, 64'h3F8, 64'hA5A5_5A5A_0102_0304, rd, er, lat);
        checkOutput("sd_3f8_lat", 64'(lat), 64'd2);
        checkOutput("sd_3f8_err", 64'(er), 64'd0);
        checkOutput("sd_3f8_rd_cycles", 64'(rdCnt), 64'd0);
        checkOutput("sd_3f8_mem", getMem64(1016), 64'hA5A5_5A5A_0102_0304);
        applyStimulus(1'b1, 2'b11, 1'b0, 64'h3F9, 64'h1234, rd, er, lat);
        checkOutput("sd_3f9_lat", 64'(lat), 64'd1);
        checkOutput("sd_3f9_err", 64'(er), 64'd1);
        checkOutput("sd_3f9_strobes", 64'(rdCnt + wrCnt), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 64'h1_0000_0000, 64'h0, rd, er, lat);
        checkOutput("lb_huge_err", 64'(er), 64'd1);
        checkOutput("lb_huge_lat", 64'(lat), 64'd1);

        // Memory error during the read half of a read-modify-write.
        setMem64(64, 64'h0A0B_0C0D_0E0F_1011);
        errOnRead = 1'b1;
        applyStimulus(1'b1, 2'b10, 1'b0, 64'h40, 64'h1234_5678, rd, er, lat);
        errOnRead = 1'b0;
        checkOutput("sw_err_err", 64'(er), 64'd1);
        checkOutput("sw_err_lat", 64'(lat), 64'd2);
        checkOutput("sw_err_wr_cycles", 64'(wrCnt), 64'd0);
        checkOutput("sw_err_mem", getMem64(64), 64'h0A0B_0C0D_0E0F_1011);

        // req_valid held high across two loads.
        @(negedge clk);
        rdCnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 64'h10;
        @(negedge clk);
        checkOutput("hold_ready_load", 64'(req_ready), 64'd0);
        @(negedge clk);
        checkOutput("hold_ready_resp", 64'(req_ready), 64'd0);
        checkOutput("hold_valid_resp", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        checkOutput("hold_ready_idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("hold_second_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        checkOutput("hold_second_rsp", 64'(rsp_valid), 64'd1);
        checkOutput("hold_second_data", rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("hold_rd_cycles", 64'(rdCnt), 64'd2);
        @(negedge clk);

        // Async reset while the write strobe is up.
        setMem64(256, 64'h0102_0304_0506_0708);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_addr = 64'h100;
        req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_wr_before", 64'(mem_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        checkOutput("abort_ready", 64'(req_ready), 64'd1);
        checkOutput("abort_rdata", rsp_rdata, 64'd0);
        checkOutput("abort_valid_err", {62'd0, rsp_valid, rsp_error}, 64'd0);
        checkOutput("abort_addr", mem_addr, 64'd0);
        checkOutput("abort_wdata", mem_data_wr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready_after", 64'(req_ready), 64'd1);
        checkOutput("abort_mem", getMem64(256), 64'h0102_0304_0506_0708);
        checkLoad("abort_ld", 2'b11, 1'b0, 64'h100, 64'h0102_0304_0506_0708);

        checkOutput("never_both_strobes", 64'(bothCnt), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
